// File: rtl/lock_det_pkg.sv
// rtl/lock_det_pkg.sv - carrier lock detector shared types, widths and helpers
package lock_det_pkg;

    localparam int CNT_W = 16;
    localparam int AVG_W = 16;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // A programmed count of zero behaves like one qualifying sample.
    function automatic logic [CNT_W-1:0] minOne(input logic [CNT_W-1:0] v);
        return (v == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : v;
    endfunction

endpackage

// File: rtl/lock_mag_avg.sv
// rtl/lock_mag_avg.sv - saturating |error| and 8.8 exponential magnitude averager
module lock_mag_avg
    import lock_det_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clkEn,
    input  logic [7:0] error,
    input  logic [2:0] avgExp,
    output logic [7:0] avgInt,
    output logic [7:0] nextInt
);

    logic [7:0]              absErr;
    logic [AVG_W-1:0]        magAvg;
    logic [AVG_W-1:0]        avgNext;
    logic signed [AVG_W:0]   diff;
    logic signed [AVG_W:0]   step;

    always_comb begin
        if (error == 8'h80) begin
            absErr = 8'd127;
        end else if (error[7]) begin
            absErr = -error;
        end else begin
            absErr = error;
        end
    end

    // 17-bit signed difference keeps the step exact; the result always lands in 0..0x7F00.
    always_comb begin
        diff    = $signed({1'b0, absErr, 8'h00}) - $signed({1'b0, magAvg});
        step    = diff >>> avgExp;
        avgNext = AVG_W'({1'b0, magAvg} + step);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            magAvg <= '0;
        end else if (clkEn) begin
            magAvg <= avgNext;
        end
    end

    assign avgInt  = magAvg[AVG_W-1:8];
    assign nextInt = avgNext[AVG_W-1:8];

endmodule

// File: rtl/carrier_lock_detect.sv
// rtl/carrier_lock_detect.sv - carrier lock detector FSM; LOCK_DET_CLEAR_EN enables the integrator clear pulse
module carrier_lock_detect
    import lock_det_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clkEn,
    input  logic        enable,
    input  logic [7:0]  error,
    input  logic [2:0]  avgExp,
    input  logic [7:0]  lockThreshold,
    input  logic [15:0] lockCount,
    input  logic [15:0] unlockCount,
    output logic        carrierInSync,
    output logic        sweepEnable,
    output logic        clearAccum,
    output logic [1:0]  lockState,
    output logic [7:0]  errMag
);

`ifdef LOCK_DET_CLEAR_EN
    localparam logic CLEAR_EN = 1'b1;
`else
    localparam logic CLEAR_EN = 1'b0;
`endif

    lock_state_t      state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countInc;
    logic [7:0]       nextInt;
    logic             below;

    lock_mag_avg u_mag_avg (
        .clk     (clk),
        .reset_n (reset_n),
        .clkEn   (clkEn),
        .error   (error),
        .avgExp  (avgExp),
        .avgInt  (errMag),
        .nextInt (nextInt)
    );

    assign countInc  = satInc(count);
    assign lockState = state;

    // The comparison flag trails the averager by one strobe, so the first strobe after reset never qualifies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            below <= 1'b0;
        end else if (clkEn) begin
            below <= (nextInt < lockThreshold);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= SEARCH;
            count         <= '0;
            carrierInSync <= 1'b0;
            sweepEnable   <= 1'b0;
            clearAccum    <= 1'b0;
        end else begin
            clearAccum <= 1'b0;
            if (!enable) begin
                state         <= SEARCH;
                count         <= '0;
                carrierInSync <= 1'b0;
                sweepEnable   <= 1'b0;
            end else begin
                carrierInSync <= (state == LOCKED);
                sweepEnable   <= (state == SEARCH);
                if (clkEn) begin
                    case (state)
                        SEARCH: begin
                            if (below) begin
                                state       <= VERIFY;
                                count       <= '0;
                                sweepEnable <= 1'b0;
                            end
                        end
                        VERIFY: begin
                            if (!below) begin
                                state       <= SEARCH;
                                count       <= '0;
                                sweepEnable <= 1'b1;
                            end else if (countInc >= minOne(lockCount)) begin
                                state         <= LOCKED;
                                count         <= '0;
                                carrierInSync <= 1'b1;
                            end else begin
                                count <= countInc;
                            end
                        end
                        LOCKED: begin
                            if (below) begin
                                count <= '0;
                            end else if (countInc >= minOne(unlockCount)) begin
                                state         <= SEARCH;
                                count         <= '0;
                                carrierInSync <= 1'b0;
                                sweepEnable   <= 1'b1;
                                clearAccum    <= CLEAR_EN;
                            end else begin
                                count <= countInc;
                            end
                        end
                        default: begin
                            state         <= SEARCH;
                            count         <= '0;
                            carrierInSync <= 1'b0;
                            sweepEnable   <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_carrier_lock_detect.sv
// tb/tb_carrier_lock_detect.sv - directed self-checking bench for carrier_lock_detect
module tb_carrier_lock_detect;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clkEn = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  error = 8'd0;
    logic [2:0]  avgExp = 3'd0;
    logic [7:0]  lockThreshold = 8'd0;
    logic [15:0] lockCount = 16'd10;
    logic [15:0] unlockCount = 16'd5;
    logic        carrierInSync;
    logic        sweepEnable;
    logic        clearAccum;
    logic [1:0]  lockState;
    logic [7:0]  errMag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] err;
        logic [2:0] exp;
        logic [7:0] mag;
    } vec_t;

    vec_t vecs[8];

`ifdef LOCK_DET_CLEAR_EN
    localparam logic EXP_CLR = 1'b1;
`else
    localparam logic EXP_CLR = 1'b0;
`endif

    carrier_lock_detect dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clkEn         (clkEn),
        .enable        (enable),
        .error         (error),
        .avgExp        (avgExp),
        .lockThreshold (lockThreshold),
        .lockCount     (lockCount),
        .unlockCount   (unlockCount),
        .carrierInSync (carrierInSync),
        .sweepEnable   (sweepEnable),
        .clearAccum    (clearAccum),
        .lockState     (lockState),
        .errMag        (errMag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        clkEn = 1'b1;
        @(posedge clk);
        #1;
        clkEn = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        clkEn   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{8'h80, 3'd0, 8'd127};
        vecs[1] = '{8'h00, 3'd1, 8'd63};
        vecs[2] = '{8'h00, 3'd1, 8'd31};
        vecs[3] = '{8'hEC, 3'd2, 8'd28};
        vecs[4] = '{8'h7F, 3'd3, 8'd41};
        vecs[5] = '{8'h05, 3'd7, 8'd40};
        vecs[6] = '{8'hFF, 3'd0, 8'd1};
        vecs[7] = '{8'h7F, 3'd0, 8'd127};

        // Averager table: threshold 0 keeps the FSM parked in SEARCH.
        enable = 1'b1;
        lockThreshold = 8'd0;
        doReset();
        chk("reset_errMag", 16'(errMag), 16'd0);
        chk("reset_lockState", 16'(lockState), 16'd0);
        idle();
        chk("release_sweep", 16'(sweepEnable), 16'd1);
        for (int i = 0; i < 8; i++) begin
            error  = vecs[i].err;
            avgExp = vecs[i].exp;
            step();
            chk($sformatf("avg_mag[%0d]", i), 16'(errMag), 16'(vecs[i].mag));
            chk($sformatf("avg_state[%0d]", i), 16'(lockState), 16'd0);
        end

        // Acquisition
        error = 8'd4; avgExp = 3'd0; lockThreshold = 8'd16;
        lockCount = 16'd10; unlockCount = 16'd5;
        doReset();
        idle();
        chk("acq_sweep_start", 16'(sweepEnable), 16'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1)  chk("acq_k1_state", 16'(lockState), 16'd0);
            if (k == 2)  chk("acq_k2_state", 16'(lockState), 16'd1);
            if (k == 11) chk("acq_k11_sync", 16'(carrierInSync), 16'd0);
            if (k == 12) begin
                chk("acq_k12_state", 16'(lockState), 16'd2);
                chk("acq_k12_sync", 16'(carrierInSync), 16'd1);
                chk("acq_k12_sweep", 16'(sweepEnable), 16'd0);
            end
        end

        // Unlock
        error = 8'd100;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k < 6) begin
                chk("unl_state", 16'(lockState), 16'd2);
                chk("unl_clr_early", 16'(clearAccum), 16'd0);
            end
        end
        chk("unl_state6", 16'(lockState), 16'd0);
        chk("unl_clr6", 16'(clearAccum), 16'(EXP_CLR));
        chk("unl_sync6", 16'(carrierInSync), 16'd0);
        chk("unl_sweep6", 16'(sweepEnable), 16'd1);
        idle();
        chk("unl_clr_once", 16'(clearAccum), 16'd0);

        // Aborted verify at count 7 of 10
        error = 8'd4;
        step();
        step();
        chk("abort_enter", 16'(lockState), 16'd1);
        for (int k = 0; k < 7; k++) step();
        chk("abort_cnt7", 16'(lockState), 16'd1);
        error = 8'd50;
        step();
        chk("abort_lag", 16'(lockState), 16'd1);
        step();
        chk("abort_state", 16'(lockState), 16'd0);
        chk("abort_clr", 16'(clearAccum), 16'd0);
        chk("abort_sweep", 16'(sweepEnable), 16'd1);

        // Enable drop in LOCKED
        error = 8'd4;
        for (int k = 0; k < 12; k++) step();
        chk("drop_pre_state", 16'(lockState), 16'd2);
        enable = 1'b0;
        idle();
        chk("drop_state", 16'(lockState), 16'd0);
        chk("drop_sync", 16'(carrierInSync), 16'd0);
        chk("drop_sweep", 16'(sweepEnable), 16'd0);
        chk("drop_clr", 16'(clearAccum), 16'd0);
        chk("drop_mag", 16'(errMag), 16'd4);
        enable = 1'b1;
        idle();
        chk("reenable_sweep", 16'(sweepEnable), 16'd1);

        // Reset mid-LOCKED
        begin
            int n = 0;
            while (lockState != 2'd2 && n < 20) begin
                step();
                n++;
            end
            chk("relock", 16'(lockState), 16'd2);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_sync", 16'(carrierInSync), 16'd0);
        chk("rst_state", 16'(lockState), 16'd0);
        chk("rst_sweep", 16'(sweepEnable), 16'd0);
        chk("rst_clr", 16'(clearAccum), 16'd0);
        chk("rst_mag", 16'(errMag), 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();
        chk("rst_rel_sweep", 16'(sweepEnable), 16'd1);
        chk("rst_rel_state", 16'(lockState), 16'd0);
        chk("rst_rel_clr", 16'(clearAccum), 16'd0);

        // lockCount of zero acts as one
        lockCount = 16'd0;
        step();
        step();
        chk("lc0_verify", 16'(lockState), 16'd1);
        step();
        chk("lc0_locked", 16'(lockState), 16'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
